ika2151_timinggen: RTL and testbench
====================================

# ika2151_timinggen

Master timing controller for the IKA2151 datapath. It divides the master-clock enable into the phi1 positive and negative clock-enable pulses that drive every primitive counter and shift register. It also runs the 32-slot operator counter and produces the cycle-boundary counter reset for BRAM-backed shift registers. It sequences reset by holding datapath state in reset for a programmable number of full slot cycles after IC release, so the shift-register contents are flushed before normal operation begins.

## Interface
Parameters:
- SLOT_COUNT, 32, slots per operator cycle (power of two, ≥4)
- FLUSH_CYCLES, 2, full slot cycles held in flush after reset release (≥1)

Ports:
- i_EMUCLK  in  1  emulator clock; single clock domain
- i_IC_n  in  1  reset; **asynchronous, active-low**
- i_phiMCEN_n  in  1  master-clock enable, active-low, one i_EMUCLK wide
- o_phi1_PCEN_n  out  1  phi1 rising-edge enable, active-low pulse
- o_phi1_NCEN_n  out  1  phi1 falling-edge enable, active-low pulse
- o_SLOT  out  log2(SLOT_COUNT)  current operator slot
- o_CNTRRST  out  1  shift-register counter reset (drives BRAM SR i_CNTRRST)
- o_RST  out  1  active-high datapath reset (drives counter i_RST)
- o_READY  out  1  high in RUN state

## Operation
- Phase flag `ph`. On each edge where i_phiMCEN_n=0 is sampled, `ph` toggles.
  - If `ph` was 0, o_phi1_PCEN_n is registered low for one cycle.
  - If `ph` was 1, o_phi1_NCEN_n is registered low for one cycle.
  - Otherwise both are registered high. The two pulses never overlap.
- o_SLOT increments on every edge that samples o_phi1_PCEN_n=0. It wraps SLOT_COUNT-1 → 0. While a PCEN pulse is active, o_SLOT shows the slot being processed.
- o_CNTRRST = 1 in RESET state; otherwise 1 iff o_SLOT == SLOT_COUNT-1.
- FSM, three states:
  - **RESET**: entered asynchronously whenever i_IC_n=0. `ph`, slot and flush counter are cleared. Leaves for FLUSH on the first edge with i_IC_n=1.
  - **FLUSH**: phi1 enables and the slot counter run; o_RST=1. A flush counter increments on each slot wrap (SLOT_COUNT-1 → 0 on a PCEN-consume edge). On the wrap where the counter equals FLUSH_CYCLES-1, the FSM moves to RUN.
  - **RUN**: o_RST=0 and o_READY=1. Remains until i_IC_n=0.
- Reset values: o_phi1_PCEN_n=1, o_phi1_NCEN_n=1, o_SLOT=0, o_CNTRRST=1, o_RST=1, o_READY=0.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). A PCEN/NCEN pulse in flight is truncated.
- i_phiMCEN_n is ignored in RESET.
- Consecutive enables (i_phiMCEN_n held low) are legal and give the fastest rate, one phi1 half-period per i_EMUCLK.

## Timing
- Enable latency: a phiM enable sampled at edge E produces the PCEN/NCEN pulse during cycle E→E+1.
- Slot counter and FSM update at edge E+1, the edge that consumes the pulse.
- With i_phiMCEN_n tied 0:
  - PCEN is low after odd edges and NCEN after even edges, counting the edges after reset release.
  - o_SLOT advances every 2 cycles.
- The first pulse after reset is always PCEN.
- o_RST falls and o_READY rises on the edge that consumes the (FLUSH_CYCLES·SLOT_COUNT)-th PCEN pulse. o_SLOT is 0 at that point.
- o_CNTRRST is combinational from registered state: glitch-free and stable for the whole PCEN pulse of the last slot.

## Structure
- Shared package ika2151_pkg: the SLOT_COUNT default, the slot-width constant, and the FSM state type (RESET, FLUSH, RUN).
- One natural sub-module, ika2151_cengen: the phase flag and the PCEN/NCEN pulse registers, with inputs i_EMUCLK, i_IC_n and i_phiMCEN_n.
- The slot counter, flush counter and FSM live in the top module.

## Test plan
- **Default enable rate:** i_phiMCEN_n tied 0, release i_IC_n → first PCEN after edge 1, NCEN after edge 2, strictly alternating; o_SLOT steps 0,1,2… every 2 cycles.
- **Flush length:** defaults (FLUSH_CYCLES=2) → o_RST=1 and o_READY=0 through 63 PCEN pulses; on the edge consuming the 64th PCEN pulse (edge 128), o_READY=1, o_RST=0 and o_SLOT=0.
- **Slot wrap and CNTRRST:** in RUN, o_CNTRRST=1 exactly while o_SLOT=31; the next PCEN consumption gives o_SLOT=0 and o_CNTRRST=0.
- **Sparse enables:** i_phiMCEN_n low every 4th cycle → one-cycle PCEN pulses spaced 8 cycles apart, NCEN offset by 4 cycles; o_SLOT period is 256 cycles.
- **Mid-run reset:** assert i_IC_n while o_SLOT=17 with a PCEN pulse active → same timestep: PCEN_n=1, o_SLOT=0, o_RST=1, o_READY=0, o_CNTRRST=1; after release the flush repeats in full.
- **Minimum flush:** FLUSH_CYCLES=1, SLOT_COUNT=4, tied enable → o_READY rises at edge 8.

Source files
------------

// File: rtl/ika2151_pkg.sv
// Shared constants and FSM state encoding for the IKA2151 timing generator.
package ika2151_pkg;

  localparam int SLOT_COUNT_DEF = 32;
  localparam int SLOT_W         = $clog2(SLOT_COUNT_DEF);

  typedef logic [1:0] state_t;

  localparam state_t ST_RESET = 2'd0;
  localparam state_t ST_FLUSH = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

endpackage

// File: rtl/ika2151_cengen.sv
// phi1 clock-enable generator: splits the master-clock enable into alternating
// positive/negative edge enable pulses, starting with PCEN after reset.
module ika2151_cengen (
  input  logic i_EMUCLK,
  input  logic i_IC_n,
  input  logic i_phiMCEN_n,
  output logic o_phi1_PCEN_n,
  output logic o_phi1_NCEN_n
);

  logic ph;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      ph            <= 1'b0;
      o_phi1_PCEN_n <= 1'b1;
      o_phi1_NCEN_n <= 1'b1;
    end else if (!i_phiMCEN_n) begin
      ph            <= ~ph;
      o_phi1_PCEN_n <= ph;
      o_phi1_NCEN_n <= ~ph;
    end else begin
      o_phi1_PCEN_n <= 1'b1;
      o_phi1_NCEN_n <= 1'b1;
    end
  end

endmodule

// File: rtl/ika2151_timinggen.sv
// Master timing controller: phi1 enables, operator slot counter, and the
// reset/flush sequencer that holds the datapath in reset for whole slot cycles.
//
//   state    | meaning
//   ST_RESET | IC asserted; everything cleared, outputs at reset values
//   ST_FLUSH | enables and slots run, datapath held in reset to flush SRs
//   ST_RUN   | normal operation, o_READY high
module ika2151_timinggen
  import ika2151_pkg::*;
#(
  parameter int SLOT_COUNT   = SLOT_COUNT_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          i_EMUCLK,
  input  logic                          i_IC_n,
  input  logic                          i_phiMCEN_n,
  output logic                          o_phi1_PCEN_n,
  output logic                          o_phi1_NCEN_n,
  output logic [$clog2(SLOT_COUNT)-1:0] o_SLOT,
  output logic                          o_CNTRRST,
  output logic                          o_RST,
  output logic                          o_READY
);

  localparam int SW = $clog2(SLOT_COUNT);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_COUNT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_t        state;
  logic [SW-1:0] slot;
  logic [FW-1:0] flush_cnt;
  logic          slot_wrap;

  ika2151_cengen u_cengen (
    .i_EMUCLK      (i_EMUCLK),
    .i_IC_n        (i_IC_n),
    .i_phiMCEN_n   (i_phiMCEN_n),
    .o_phi1_PCEN_n (o_phi1_PCEN_n),
    .o_phi1_NCEN_n (o_phi1_NCEN_n)
  );

  // A wrap is the edge consuming the PCEN pulse of the last slot.
  assign slot_wrap = !o_phi1_PCEN_n && (slot == SLOT_LAST);

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      slot <= '0;
    end else if (!o_phi1_PCEN_n) begin
      slot <= slot + SW'(1);
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state     <= ST_RESET;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state     <= ST_FLUSH;
          flush_cnt <= '0;
        end
        ST_FLUSH: begin
          if (slot_wrap) begin
            if (flush_cnt == FLUSH_LAST) begin
              state     <= ST_RUN;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + FW'(1);
            end
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state     <= ST_RESET;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  assign o_SLOT    = slot;
  assign o_CNTRRST = (state == ST_RESET) || (slot == SLOT_LAST);
  assign o_RST     = (state != ST_RUN);
  assign o_READY   = (state == ST_RUN);

endmodule

// File: tb/tb_ika2151_timinggen.sv
// Scoreboard bench for ika2151_timinggen: default and minimum-flush instances.
module tb_ika2151_timinggen;

  logic       clk = 1'b0;
  logic       ic_n = 1'b0;
  logic       mcen_n = 1'b0;
  logic       ic_n_b = 1'b0;
  logic       mcen_b = 1'b0;

  logic       pc_a, nc_a, cr_a, rst_a, rdy_a;
  logic [4:0] slot_a;
  logic       pc_b, nc_b, cr_b, rst_b, rdy_b;
  logic [1:0] slot_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    int         k;
    bit         chk_b;
    logic       pc, nc, cr, rst, rdy;
    logic [4:0] slot;
    logic       pc_b, nc_b, cr_b, rst_b, rdy_b;
    logic [1:0] slot_b;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;

  always #5 clk = ~clk;

  ika2151_timinggen dut_a (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n),
    .i_phiMCEN_n   (mcen_n),
    .o_phi1_PCEN_n (pc_a),
    .o_phi1_NCEN_n (nc_a),
    .o_SLOT        (slot_a),
    .o_CNTRRST     (cr_a),
    .o_RST         (rst_a),
    .o_READY       (rdy_a)
  );

  ika2151_timinggen #(.SLOT_COUNT(4), .FLUSH_CYCLES(1)) dut_b (
    .i_EMUCLK      (clk),
    .i_IC_n        (ic_n_b),
    .i_phiMCEN_n   (mcen_b),
    .o_phi1_PCEN_n (pc_b),
    .o_phi1_NCEN_n (nc_b),
    .o_SLOT        (slot_b),
    .o_CNTRRST     (cr_b),
    .o_RST         (rst_b),
    .o_READY       (rdy_b)
  );

  function automatic exp_t reset_exp(string nm, bit with_b);
    exp_t e;
    e.name = nm; e.k = 0; e.chk_b = with_b;
    e.pc = 1'b1; e.nc = 1'b1; e.slot = 5'd0; e.cr = 1'b1; e.rst = 1'b1; e.rdy = 1'b0;
    e.pc_b = 1'b1; e.nc_b = 1'b1; e.slot_b = 2'd0; e.cr_b = 1'b1; e.rst_b = 1'b1; e.rdy_b = 1'b0;
    return e;
  endfunction

  // Enable tied low: k counts edges after IC release.
  function automatic exp_t tied_exp(string nm, int k, bit with_b);
    exp_t e;
    int   s, sb;
    e.name = nm; e.k = k; e.chk_b = with_b;
    s  = (k / 2) % 32;
    sb = (k / 2) % 4;
    e.pc = (k % 2 == 1) ? 1'b0 : 1'b1;
    e.nc = (k >= 2 && k % 2 == 0) ? 1'b0 : 1'b1;
    e.slot = 5'(s);
    e.cr = (s == 31);
    e.rdy = (k >= 128);
    e.rst = !e.rdy;
    e.pc_b = e.pc; e.nc_b = e.nc;
    e.slot_b = 2'(sb);
    e.cr_b = (sb == 3);
    e.rdy_b = (k >= 8);
    e.rst_b = !e.rdy_b;
    return e;
  endfunction

  // Enable low on edges k%4==1: PCEN after k%8==1, NCEN after k%8==5.
  function automatic exp_t sparse_exp(int k);
    exp_t e;
    int   s;
    e = reset_exp("sparse", 1'b0);
    e.k = k;
    s = ((k + 6) / 8) % 32;
    e.pc = (k % 8 == 1) ? 1'b0 : 1'b1;
    e.nc = (k % 8 == 5) ? 1'b0 : 1'b1;
    e.slot = 5'(s);
    e.cr = (s == 31);
    e.rdy = (k >= 506);
    e.rst = !e.rdy;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({pc_a, nc_a, slot_a, cr_a, rst_a, rdy_a} !== {e.pc, e.nc, e.slot, e.cr, e.rst, e.rdy}) begin
          miscompares++;
          $display("FAIL %s k=%0d dut_a: got pc=%b nc=%b slot=%0d cr=%b rst=%b rdy=%b, want pc=%b nc=%b slot=%0d cr=%b rst=%b rdy=%b",
                   e.name, e.k, pc_a, nc_a, slot_a, cr_a, rst_a, rdy_a, e.pc, e.nc, e.slot, e.cr, e.rst, e.rdy);
        end
        if (e.chk_b) begin
          vectors++;
          if ({pc_b, nc_b, slot_b, cr_b, rst_b, rdy_b} !== {e.pc_b, e.nc_b, e.slot_b, e.cr_b, e.rst_b, e.rdy_b}) begin
            miscompares++;
            $display("FAIL %s k=%0d dut_b: got pc=%b nc=%b slot=%0d cr=%b rst=%b rdy=%b, want pc=%b nc=%b slot=%0d cr=%b rst=%b rdy=%b",
                     e.name, e.k, pc_b, nc_b, slot_b, cr_b, rst_b, rdy_b, e.pc_b, e.nc_b, e.slot_b, e.cr_b, e.rst_b, e.rdy_b);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1 exp_q.push_back(reset_exp("reset", 1'b1));

    // Tied enable: release both together, run through flush and a RUN-state wrap.
    @(negedge clk);
    ic_n = 1'b1; ic_n_b = 1'b1; mcen_n = 1'b0;
    for (int k = 1; k <= 227; k++) begin
      @(posedge clk);
      #1 exp_q.push_back(tied_exp("tied", k, 1'b1));
      if (k < 227) @(negedge clk);
    end

    // k=227: slot 17 with PCEN active; assert IC mid-pulse.
    @(negedge clk);
    #1 ic_n = 1'b0;
    #1 exp_q.push_back(reset_exp("midrun_reset", 1'b0));
    -> chk_ev;
    repeat (2) @(posedge clk);
    #1 exp_q.push_back(reset_exp("held_reset", 1'b0));

    // Flush must repeat in full after release.
    @(negedge clk);
    ic_n = 1'b1;
    for (int k = 1; k <= 132; k++) begin
      @(posedge clk);
      #1 exp_q.push_back(tied_exp("reflush", k, 1'b0));
      @(negedge clk);
    end

    // Sparse enables: one enable every fourth cycle.
    ic_n = 1'b0;
    #1 exp_q.push_back(reset_exp("sparse_reset", 1'b0));
    -> chk_ev;
    @(negedge clk);
    ic_n = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      mcen_n = (k % 4 == 1) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1 exp_q.push_back(sparse_exp(k));
      @(negedge clk);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
